// File: rtl/rv_pkg.sv
// Shared RV32I definitions: instruction formats, base opcodes and the loader FSM states.
// Also used by the control unit decoder, so keep encodings stable.
package rv_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True when imm[31:msb] are all equal, i.e. imm fits a signed field of msb+1 bits.
    function automatic logic sext_fits(input logic [31:0] imm, input int unsigned msb);
        logic [31:0] t;
        t = $signed(imm) >>> msb;
        return (t == 32'h0) || (t == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/instr_format_encoder.sv
// Combinational RV32I field packer: builds the 32-bit word for a format and flags
// immediates that cannot be represented in that format.
module instr_format_encoder
    import rv_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic is_shift;

    always_comb begin
        word     = 32'h0;
        illegal  = 1'b0;
        is_shift = (opcode == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));
        case (fmt)
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
                if (is_shift) begin
                    word    = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                    illegal = (imm[31:5] != 27'h0);
                end else begin
                    word    = {imm[11:0], rs1, funct3, rd, opcode};
                    illegal = !sext_fits(imm, 11);
                end
            end
            FMT_S: begin
                word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                illegal = !sext_fits(imm, 11);
            end
            FMT_B: begin
                word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                illegal = !sext_fits(imm, 12) || imm[0];
            end
            FMT_U: begin
                word    = {imm[31:12], rd, opcode};
                illegal = (imm[11:0] != 12'h0);
            end
            FMT_J: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                illegal = !sext_fits(imm, 20) || imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_program_loader.sv
// Boot-time IMEM writer: encodes field-level requests into consecutive instruction words
// and holds the core in reset until the load session has been closed.
module imem_program_loader
    import rv_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    localparam int         CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             finish,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic [CNT_W-1:0] word_count,
    output logic             err,
    output logic             busy,
    output logic             core_rst_n,
    output logic [1:0]       dbg_state
);

    // Handshake: a request transfers on a rising edge where in_valid & in_ready;
    // in_ready depends only on state and fill level, never on in_valid.
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             core_rst_n_q, core_rst_n_d;
    logic [31:0]      enc_word;
    logic             enc_illegal;
    logic             accept;

    instr_format_encoder u_enc (
        .fmt     (in_fmt),
        .opcode  (in_opcode),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .funct3  (in_funct3),
        .funct7  (in_funct7),
        .imm     (in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign in_ready = (state_q == ST_LOAD) && (count_q < DEPTH_C);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                    addr_d  = BASE_ADDR;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    // Rejected requests are still consumed so the producer never stalls on them.
                    if (enc_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = BASE_ADDR + (32'(count_q) << 2);
                        wdata_d = enc_word;
                        count_d = count_q + 1'b1;
                        if (count_q == LAST_C) state_d = ST_DONE;
                    end
                end
                if (finish) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Release the core only once DONE has been held for a cycle; drop it as a new session opens.
        core_rst_n_d = (state_q == ST_DONE) && (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            addr_q       <= BASE_ADDR;
            wdata_q      <= 32'h0;
            count_q      <= '0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            count_q      <= count_d;
            err_q        <= err_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = count_q;
    assign err        = err_q;
    assign busy       = (state_q == ST_LOAD);
    assign core_rst_n = core_rst_n_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader (DEPTH=4): directed scenarios plus random sessions,
// with every IMEM write checked against an expected {addr, data} queue.
module tb_imem_program_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n, start, finish, in_valid, in_ready;
    logic [2:0]       in_fmt, in_funct3;
    logic [6:0]       in_opcode, in_funct7;
    logic [4:0]       in_rd, in_rs1, in_rs2;
    logic [31:0]      in_imm, imem_addr, imem_wdata;
    logic             imem_we, err, busy, core_rst_n;
    logic [CNT_W-1:0] word_count;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    imem_program_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .word_count(word_count), .err(err), .busy(busy),
        .core_rst_n(core_rst_n), .dbg_state(dbg_state)
    );

    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          m_state;   // 0 idle, 1 load, 2 done
    int          m_count;
    logic        m_err;

    // Reference encoder built from shifts and integer ranges.
    function automatic logic [32:0] model_enc(input logic [2:0] fmt, input logic [6:0] op,
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] w;
        logic [31:0] regs;
        logic        ok;
        int          s;
        s    = int'($signed(imm));
        regs = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        w    = 32'h0;
        ok   = 1'b0;
        case (fmt)
            3'd0: begin
                w  = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7);
                ok = 1'b1;
            end
            3'd1: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    w  = (32'(f7) << 25) | ((imm & 32'h1F) << 20) | regs | (32'(rd) << 7);
                    ok = (imm < 32'd32);
                end else begin
                    w  = ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7);
                    ok = (s >= -2048) && (s <= 2047);
                end
            end
            3'd2: begin
                w  = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs | ((imm & 32'h1F) << 7);
                ok = (s >= -2048) && (s <= 2047);
            end
            3'd3: begin
                w  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
                   | regs | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
                ok = (s >= -4096) && (s <= 4095) && ((imm & 32'h1) == 32'h0);
            end
            3'd4: begin
                w  = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
                ok = ((imm & 32'hFFF) == 32'h0);
            end
            3'd5: begin
                w  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                   | (32'(rd) << 7) | 32'(op);
                ok = (s >= -1048576) && (s <= 1048575) && ((imm & 32'h1) == 32'h0);
            end
            default: ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    // Scoreboard: every write strobe must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && imem_we === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write got addr=%h data=%h required no write", imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== mon_e) begin
                    n_err++;
                    $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                             imem_addr, imem_wdata, mon_e[63:32], mon_e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        if (m_state != 1) begin
            m_state = 1;
            m_count = 0;
            m_err   = 1'b0;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic do_finish();
        finish = 1'b1;
        if (m_state == 1) m_state = 2;
        tick();
        finish = 1'b0;
    endtask

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
        input logic [6:0] f7, input logic [31:0] imm, input logic fin);
        logic [32:0] r;
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        in_valid = 1'b1;
        finish   = fin;
        r = model_enc(fmt, op, rd, rs1, rs2, f3, f7, imm);
        if (m_state == 1) begin
            if (r[32]) begin
                exp_q.push_back({BASE + 32'(m_count) * 32'd4, r[31:0]});
                m_count++;
                if (m_count == DEPTH) m_state = 2;
            end else begin
                m_err = 1'b1;
            end
            if (fin) m_state = 2;
        end
        tick();
        in_valid = 1'b0;
        finish   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
        m_state = 0; m_count = 0; m_err = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b0, BASE, 32'h0}) begin
            n_err++;
            $display("FAIL reset_write_port got we=%b addr=%h data=%h required 0/%h/0", imem_we, imem_addr, imem_wdata, BASE);
        end
        n_vec++;
        if ({word_count, err, busy, core_rst_n, in_ready, dbg_state} !== {CNT_W'(0), 4'b0000, 2'd0}) begin
            n_err++;
            $display("FAIL reset_status got cnt=%0d err=%b busy=%b core_rst_n=%b rdy=%b st=%0d required all 0",
                     word_count, err, busy, core_rst_n, in_ready, dbg_state);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        do_start();
        n_vec++;
        if ({in_ready, busy, core_rst_n} !== 3'b110) begin
            n_err++;
            $display("FAIL load_status got rdy=%b busy=%b core_rst_n=%b required 1 1 0", in_ready, busy, core_rst_n);
        end
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        n_vec++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h0, 32'h0050_0093}) begin
            n_err++;
            $display("FAIL addi got we=%b addr=%h data=%h required 1/00000000/00500093", imem_we, imem_addr, imem_wdata);
        end
        tick();
        n_vec++;
        if (imem_we !== 1'b0 || word_count !== CNT_W'(1)) begin
            n_err++;
            $display("FAIL addi_single_strobe got we=%b cnt=%0d required 0 1", imem_we, word_count);
        end
        do_finish();
        n_vec++;
        if ({busy, core_rst_n, dbg_state} !== {2'b00, 2'd2}) begin
            n_err++;
            $display("FAIL finish_enter got busy=%b core_rst_n=%b st=%0d required 0 0 2", busy, core_rst_n, dbg_state);
        end
        tick();
        n_vec++;
        if (core_rst_n !== 1'b1) begin
            n_err++;
            $display("FAIL finish_release got core_rst_n=%b required 1", core_rst_n);
        end
    endtask

    task automatic test_back_to_back();
        do_start();
        n_vec++;
        if (core_rst_n !== 1'b0 || word_count !== CNT_W'(0)) begin
            n_err++;
            $display("FAIL restart got core_rst_n=%b cnt=%0d required 0 0", core_rst_n, word_count);
        end
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        n_vec++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h0, 32'h0020_81B3}) begin
            n_err++;
            $display("FAIL add got we=%b addr=%h data=%h required 1/00000000/002081b3", imem_we, imem_addr, imem_wdata);
        end
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0);
        n_vec++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h4, 32'hFE20_8EE3}) begin
            n_err++;
            $display("FAIL beq got we=%b addr=%h data=%h required 1/00000004/fe208ee3", imem_we, imem_addr, imem_wdata);
        end
        do_finish();
    endtask

    task automatic test_jal_lui_finish();
        do_start();
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0);
        n_vec++;
        if (imem_wdata !== 32'h0080_00EF) begin
            n_err++;
            $display("FAIL jal got data=%h required 008000ef", imem_wdata);
        end
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1);
        n_vec++;
        if ({imem_we, imem_addr, imem_wdata, busy} !== {1'b1, 32'h4, 32'h1234_52B7, 1'b0}) begin
            n_err++;
            $display("FAIL lui_finish got we=%b addr=%h data=%h busy=%b required 1/00000004/123452b7/0",
                     imem_we, imem_addr, imem_wdata, busy);
        end
        tick();
        n_vec++;
        if (core_rst_n !== 1'b1 || word_count !== CNT_W'(2)) begin
            n_err++;
            $display("FAIL lui_done got core_rst_n=%b cnt=%0d required 1 2", core_rst_n, word_count);
        end
    endtask

    task automatic test_illegal();
        do_start();
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0);
        n_vec++;
        if ({imem_we, err, word_count} !== {2'b01, CNT_W'(0)}) begin
            n_err++;
            $display("FAIL illegal_b got we=%b err=%b cnt=%0d required 0 1 0", imem_we, err, word_count);
        end
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 1'b0);
        send(3'd6, 7'h33, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
        n_vec++;
        if ({imem_we, err, word_count} !== {2'b01, CNT_W'(0)}) begin
            n_err++;
            $display("FAIL illegal_i_fmt6 got we=%b err=%b cnt=%0d required 0 1 0", imem_we, err, word_count);
        end
        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 1'b0);
        n_vec++;
        if ({imem_we, imem_addr, err} !== {1'b1, 32'h0, 1'b1}) begin
            n_err++;
            $display("FAIL after_illegal got we=%b addr=%h err=%b required 1/00000000/1", imem_we, imem_addr, err);
        end
        do_finish();
        do_start();
        n_vec++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear got err=%b required 0", err);
        end
        do_finish();
    endtask

    task automatic test_depth_full();
        do_start();
        for (int i = 0; i < DEPTH; i++)
            send(3'd0, 7'h33, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), 32'd0, 1'b0);
        n_vec++;
        if ({imem_addr, word_count, busy, in_ready, dbg_state} !== {32'hC, CNT_W'(DEPTH), 2'b00, 2'd2}) begin
            n_err++;
            $display("FAIL depth_full got addr=%h cnt=%0d busy=%b rdy=%b st=%0d required 0000000c %0d 0 0 2",
                     imem_addr, word_count, busy, in_ready, dbg_state, DEPTH);
        end
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
        n_vec++;
        if (imem_we !== 1'b0 || word_count !== CNT_W'(DEPTH)) begin
            n_err++;
            $display("FAIL depth_overflow got we=%b cnt=%0d required 0 %0d", imem_we, word_count, DEPTH);
        end
    endtask

    task automatic test_reset_mid();
        do_start();
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        m_state = 0; m_count = 0; m_err = 1'b0;
        #1;
        n_vec++;
        if ({imem_we, imem_addr, imem_wdata, word_count, err, busy, core_rst_n, dbg_state}
            !== {1'b0, BASE, 32'h0, CNT_W'(0), 3'b000, 2'd0}) begin
            n_err++;
            $display("FAIL mid_reset got we=%b addr=%h data=%h cnt=%0d err=%b busy=%b core_rst_n=%b required reset values",
                     imem_we, imem_addr, imem_wdata, word_count, err, busy, core_rst_n);
        end
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        n_vec++;
        if ({imem_we, imem_addr, err} !== {1'b1, BASE, 1'b0}) begin
            n_err++;
            $display("FAIL fresh_session got we=%b addr=%h err=%b required 1/%h/0", imem_we, imem_addr, err, BASE);
        end
        do_finish();
    endtask

    task automatic test_random();
        logic [31:0] imm;
        int          n;
        for (int s = 0; s < 6; s++) begin
            do_start();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) tick();
                case ($urandom_range(0, 3))
                    0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                    1: imm = $urandom();
                    2: imm = $urandom() & 32'hFFFF_F000;
                    default: imm = 32'($urandom_range(0, 4194303)) - 32'h0020_0000;
                endcase
                send(3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1) ? 7'h13 : 7'($urandom_range(0, 127)),
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), imm,
                     (i == n - 1) && ($urandom_range(0, 1) == 1));
            end
            if (m_state == 1) do_finish();
            tick();
            n_vec++;
            if (word_count !== CNT_W'(m_count) || err !== m_err || core_rst_n !== 1'b1) begin
                n_err++;
                $display("FAIL random_session%0d got cnt=%0d err=%b core_rst_n=%b required %0d %b 1",
                         s, word_count, err, core_rst_n, m_count, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_jal_lui_finish();
        test_illegal();
        test_depth_full();
        test_reset_mid();
        test_random();
        repeat (2) tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_writes got %0d pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
